// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the core's memory stage and the data-memory responder.
// A request transfers on a rising edge with req_valid and req_ready both high; resp_valid is a one-cycle pulse and the response fields are meaningful only while it is high.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: little-endian 64-bit word store with byte/half/word/double accesses,
// a fixed access latency and a one-cycle response pulse carrying read data and an error flag.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 Reset,
    data_mem_responder_if.slave  bus,
    output logic [1:0]           dbgState
);
    localparam int         AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LOAD_COUNT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } stateT;

    stateT       state;
    logic [3:0]  counter;

    logic        capWrite;
    logic        capUnsigned;
    logic [1:0]  capSize;
    logic [63:0] capAddr;
    logic [63:0] capWdata;

    logic [63:0] mem [DEPTH];

    logic [2:0]    lane;
    logic [5:0]    bitShift;
    logic [3:0]    numBytes;
    logic          misaligned;
    logic          outOfRange;
    logic          accessErr;
    logic [AW-1:0] wordIdx;
    logic [63:0]   curWord;
    logic [63:0]   widthMask;
    logic [63:0]   laneMask;
    logic [63:0]   mergedWord;
    logic [63:0]   rawLoad;
    logic [63:0]   loadData;
    logic          commitEdge;

    assign dbgState = state;

    // Access decode works entirely from the captured request, so the bus is free after acceptance.
    always_comb begin
        lane       = capAddr[2:0];
        bitShift   = {lane, 3'b000};
        numBytes   = 4'd1 << capSize;
        misaligned = (lane & 3'(numBytes - 4'd1)) != 3'd0;
        outOfRange = capAddr[63:3] >= 61'(DEPTH);
        accessErr  = misaligned | outOfRange;
        wordIdx    = capAddr[AW+2:3];
        curWord    = mem[wordIdx];

        case (capSize)
            2'd0:    widthMask = 64'h0000_0000_0000_00FF;
            2'd1:    widthMask = 64'h0000_0000_0000_FFFF;
            2'd2:    widthMask = 64'h0000_0000_FFFF_FFFF;
            default: widthMask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase

        laneMask   = widthMask << bitShift;
        mergedWord = (curWord & ~laneMask) | ((capWdata << bitShift) & laneMask);
        rawLoad    = curWord >> bitShift;

        case (capSize)
            2'd0:    loadData = capUnsigned ? {56'd0, rawLoad[7:0]}
                                            : {{56{rawLoad[7]}}, rawLoad[7:0]};
            2'd1:    loadData = capUnsigned ? {48'd0, rawLoad[15:0]}
                                            : {{48{rawLoad[15]}}, rawLoad[15:0]};
            2'd2:    loadData = capUnsigned ? {32'd0, rawLoad[31:0]}
                                            : {{32{rawLoad[31]}}, rawLoad[31:0]};
            default: loadData = rawLoad;
        endcase

        commitEdge = (state == BUSY) && (counter == 4'd0) && !Reset;
    end

    // Store contents survive Reset; a Reset on the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (commitEdge && capWrite && !accessErr) begin
            mem[wordIdx] <= mergedWord;
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state           <= IDLE;
            counter         <= 4'd0;
            bus.req_ready   <= 1'b1;
            bus.resp_valid  <= 1'b0;
            bus.resp_rdata  <= 64'd0;
            bus.resp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        capWrite      <= bus.req_write;
                        capUnsigned   <= bus.req_unsigned;
                        capSize       <= bus.req_size;
                        capAddr       <= bus.req_addr;
                        capWdata      <= bus.req_wdata;
                        counter       <= LOAD_COUNT;
                        bus.req_ready <= 1'b0;
                        state         <= BUSY;
                    end
                end
                BUSY: begin
                    if (counter != 4'd0) begin
                        counter <= counter - 4'd1;
                    end else begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= accessErr;
                        bus.resp_rdata <= (accessErr || capWrite) ? 64'd0 : loadData;
                    end
                end
                RESP: begin
                    state          <= IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.req_ready  <= 1'b1;
                end
                default: begin
                    state          <= IDLE;
                    bus.resp_valid <= 1'b0;
                    bus.req_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (latency 2, 1, 5) sharing request fields,
// checked against a byte-array model of the store.
module tb_data_mem_responder;
    localparam int DEPTH = 32;
    localparam int LAT [3] = '{2, 1, 5};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        Reset;
    logic [2:0]  reqValid;
    logic        reqWrite;
    logic        reqUnsigned;
    logic [1:0]  reqSize;
    logic [63:0] reqAddr;
    logic [63:0] reqWdata;

    logic [2:0]  respValid;
    logic [2:0]  reqReady;
    logic [2:0]  respErr;
    logic [63:0] respRdata [3];
    logic [1:0]  dbgA, dbgB, dbgC;

    data_mem_responder_if busA ();
    data_mem_responder_if busB ();
    data_mem_responder_if busC ();

    assign busA.req_valid = reqValid[0];
    assign busB.req_valid = reqValid[1];
    assign busC.req_valid = reqValid[2];
    assign busA.req_write = reqWrite;     assign busB.req_write = reqWrite;     assign busC.req_write = reqWrite;
    assign busA.req_addr = reqAddr;       assign busB.req_addr = reqAddr;       assign busC.req_addr = reqAddr;
    assign busA.req_size = reqSize;       assign busB.req_size = reqSize;       assign busC.req_size = reqSize;
    assign busA.req_unsigned = reqUnsigned; assign busB.req_unsigned = reqUnsigned; assign busC.req_unsigned = reqUnsigned;
    assign busA.req_wdata = reqWdata;     assign busB.req_wdata = reqWdata;     assign busC.req_wdata = reqWdata;

    assign respValid = {busC.resp_valid, busB.resp_valid, busA.resp_valid};
    assign reqReady  = {busC.req_ready, busB.req_ready, busA.req_ready};
    assign respErr   = {busC.resp_err, busB.resp_err, busA.resp_err};
    assign respRdata[0] = busA.resp_rdata;
    assign respRdata[1] = busB.resp_rdata;
    assign respRdata[2] = busC.resp_rdata;

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dutA (.clk(clk), .Reset(Reset), .bus(busA), .dbgState(dbgA));
    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dutB (.clk(clk), .Reset(Reset), .bus(busB), .dbgState(dbgB));
    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(5)) dutC (.clk(clk), .Reset(Reset), .bus(busC), .dbgState(dbgC));

    int           nChecks = 0;
    int           nFails  = 0;
    logic [7:0]   refMem [8*DEPTH];
    logic [64:0]  expQ [$];

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: byte-addressed array, result packed as {err, rdata}.
    function automatic logic [64:0] refAccess(input logic w, input logic [63:0] a, input logic [1:0] s,
                                              input logic u, input logic [63:0] d);
        int n = 1 << s;
        logic [63:0] v = 64'd0;
        if ((a % 64'(n)) != 64'd0 || (a / 64'd8) >= 64'(DEPTH)) return {1'b1, 64'd0};
        if (w) begin
            for (int i = 0; i < n; i++) refMem[a + 64'(i)] = d[8*i +: 8];
            return 65'd0;
        end
        for (int i = 0; i < n; i++) v[8*i +: 8] = refMem[a + 64'(i)];
        if (!u && n < 8 && v[8*n-1]) begin
            for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
        end
        return {1'b0, v};
    endfunction

    task automatic issue(input int k, input logic w, input logic [63:0] a, input logic [1:0] s,
                         input logic u, input logic [63:0] d, input logic useExp, input logic [64:0] expIn);
        int waited = 0;
        int got = 0;
        logic [64:0] model;
        @(negedge clk);
        while (!reqReady[k] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!reqReady[k]) begin
            check("ready timeout", 65'(reqReady[k]), 65'd1);
            return;
        end
        reqWrite = w; reqAddr = a; reqSize = s; reqUnsigned = u; reqWdata = d;
        reqValid[k] = 1'b1;
        @(posedge clk);
        #1;
        reqValid[k] = 1'b0;
        reqAddr = {$urandom, $urandom}; reqWdata = {$urandom, $urandom}; reqWrite = 1'($urandom);
        if (k == 0) begin
            model = refAccess(w, a, s, u, d);
            expQ.push_back(useExp ? expIn : model);
        end
        for (int e = 1; e <= 20 && got == 0; e++) begin
            @(posedge clk);
            #1;
            if (respValid[k]) got = e;
            else check("ready low while busy", 65'(reqReady[k]), 65'd0);
        end
        check("response edge", 65'(got), 65'(LAT[k]));
        if (got != 0) begin
            check("ready low in resp", 65'(reqReady[k]), 65'd0);
            @(posedge clk);
            #1;
            check("pulse one cycle", 65'(respValid[k]), 65'd0);
            check("ready back", 65'(reqReady[k]), 65'd1);
        end
    endtask

    task automatic waitIdle(input int k);
        int waited = 0;
        @(negedge clk);
        while (!reqReady[k] && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("return to idle", 65'(reqReady[k]), 65'd1);
    endtask

    task automatic holdValid(input int k, input int cycles);
        int lastAcc = -1;
        int nAcc = 0;
        logic wasReady;
        reqWrite = 1'b0; reqAddr = 64'h10; reqSize = 2'd3; reqUnsigned = 1'b0; reqWdata = 64'd0;
        @(negedge clk);
        reqValid[k] = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            wasReady = reqReady[k];
            @(posedge clk);
            if (wasReady) begin
                if (k == 0) expQ.push_back(refAccess(1'b0, 64'h10, 2'd3, 1'b0, 64'd0));
                if (lastAcc >= 0) check("accept spacing", 65'(c - lastAcc), 65'(LAT[k] + 2));
                lastAcc = c;
                nAcc++;
            end
            @(negedge clk);
        end
        reqValid[k] = 1'b0;
        check("accept count", 65'(nAcc), 65'((cycles + LAT[k] + 1) / (LAT[k] + 2)));
        waitIdle(k);
    endtask

    initial begin
        logic [1:0]  s;
        logic [63:0] a;
        int          waited;

        Reset = 1'b1; reqValid = 3'b000; reqWrite = 1'b0; reqUnsigned = 1'b0;
        reqSize = 2'd0; reqAddr = 64'd0; reqWdata = 64'd0;
        for (int i = 0; i < 8*DEPTH; i++) refMem[i] = 8'h00;

        fork
            forever begin
                @(negedge clk);
                if (respValid[0]) begin
                    if (expQ.size() == 0) begin
                        nChecks++;
                        nFails++;
                        $display("FAIL unexpected response: got err=%b rdata=%h with nothing outstanding",
                                 respErr[0], respRdata[0]);
                    end else begin
                        check("response", {respErr[0], respRdata[0]}, expQ.pop_front());
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        Reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("reset ready", 65'(reqReady[k]), 65'd1);
            check("reset resp", {respValid[k], respErr[k], respRdata[k]}, 66'd0);
        end

        // Clear the store so the model and DUT start from a known state.
        for (int w = 0; w < DEPTH; w++) issue(0, 1'b1, 64'(w * 8), 2'd3, 1'b0, 64'd0, 1'b0, 65'd0);

        issue(0, 1'b1, 64'h10, 2'd3, 1'b0, 64'h8877665544332211, 1'b1, 65'd0);
        issue(0, 1'b0, 64'h10, 2'd3, 1'b0, 64'd0, 1'b1, {1'b0, 64'h8877665544332211});
        issue(0, 1'b1, 64'h13, 2'd0, 1'b0, 64'h00000000000000AB, 1'b1, 65'd0);
        issue(0, 1'b0, 64'h10, 2'd3, 1'b0, 64'd0, 1'b1, {1'b0, 64'h88776655AB332211});
        issue(0, 1'b1, 64'h16, 2'd1, 1'b0, 64'h000000000000BEEF, 1'b1, 65'd0);
        issue(0, 1'b0, 64'h10, 2'd3, 1'b0, 64'd0, 1'b1, {1'b0, 64'hBEEF6655AB332211});
        issue(0, 1'b0, 64'h13, 2'd0, 1'b0, 64'd0, 1'b1, {1'b0, 64'hFFFFFFFFFFFFFFAB});
        issue(0, 1'b0, 64'h13, 2'd0, 1'b1, 64'd0, 1'b1, {1'b0, 64'h00000000000000AB});
        issue(0, 1'b0, 64'h14, 2'd2, 1'b0, 64'd0, 1'b1, {1'b0, 64'hFFFFFFFFBEEF6655});
        issue(0, 1'b1, 64'h11, 2'd1, 1'b0, 64'h1234, 1'b1, {1'b1, 64'd0});
        issue(0, 1'b0, 64'h10, 2'd3, 1'b0, 64'd0, 1'b1, {1'b0, 64'hBEEF6655AB332211});
        issue(0, 1'b0, 64'(8 * DEPTH), 2'd3, 1'b0, 64'd0, 1'b1, {1'b1, 64'd0});

        holdValid(0, 20);

        // Reset during BUSY aborts a byte store of 0xFF to 0x20.
        @(negedge clk);
        reqWrite = 1'b1; reqAddr = 64'h20; reqSize = 2'd0; reqUnsigned = 1'b0; reqWdata = 64'hFF;
        reqValid[0] = 1'b1;
        @(posedge clk);
        #1;
        reqValid[0] = 1'b0;
        Reset = 1'b1;
        @(posedge clk);
        #1;
        Reset = 1'b0;
        check("abort ready", 65'(reqReady[0]), 65'd1);
        check("abort state", 65'(dbgA), 65'd0);
        repeat (6) begin
            @(negedge clk);
            check("abort no response", 65'(respValid[0]), 65'd0);
        end
        issue(0, 1'b0, 64'h20, 2'd3, 1'b0, 64'd0, 1'b1, {1'b0, 64'd0});

        // Reset on the commit edge drops a store to 0x28.
        @(negedge clk);
        reqWrite = 1'b1; reqAddr = 64'h28; reqSize = 2'd3; reqWdata = 64'hCAFEF00DCAFEF00D;
        reqValid[0] = 1'b1;
        @(posedge clk);
        #1;
        reqValid[0] = 1'b0;
        @(posedge clk);
        #1;
        Reset = 1'b1;
        @(posedge clk);
        #1;
        Reset = 1'b0;
        issue(0, 1'b0, 64'h28, 2'd3, 1'b0, 64'd0, 1'b1, {1'b0, 64'd0});

        for (int t = 0; t < 80; t++) begin
            s = 2'($urandom_range(0, 3));
            a = 64'($urandom_range(0, 8 * DEPTH + 15));
            if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << s) - 1);
            issue(0, 1'($urandom), a, s, 1'($urandom), {$urandom, $urandom}, 1'b0, 65'd0);
        end

        issue(1, 1'b1, 64'h8, 2'd2, 1'b0, 64'h55, 1'b0, 65'd0);
        issue(1, 1'b0, 64'h8, 2'd2, 1'b0, 64'd0, 1'b0, 65'd0);
        holdValid(1, 12);
        issue(2, 1'b1, 64'h18, 2'd1, 1'b0, 64'h77, 1'b0, 65'd0);
        issue(2, 1'b0, 64'h18, 2'd1, 1'b1, 64'd0, 1'b0, 65'd0);
        holdValid(2, 21);

        waited = 0;
        while (expQ.size() != 0 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("queue drained", 65'(expQ.size()), 65'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
